// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix result streamer.
// Default geometry matches a 2x2 by 2x2 matrix_alu.
package matrix_pkg;

  localparam int NA = 4;
  localparam int NB = 4;

  localparam logic [1:0] OP_KRON = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_result_streamer_mux.sv
// Indexed element select from a flattened bus.
// Out-of-range selects return zero.
module matrix_result_streamer_mux
  import matrix_pkg::*;
#(
  parameter int word_size = 32,
  parameter int depth = 16,
  localparam int SW = idx_width(depth)
) (
  input  logic [depth*word_size-1:0] data,
  input  logic [SW-1:0]              sel,
  output logic [word_size-1:0]       elem
);

  always_comb begin
    elem = '0;
    for (int i = 0; i < depth; i++) begin
      if (sel == SW'(i)) begin
        elem = data[i*word_size +: word_size];
      end
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures matrix_alu's result bus after a fixed latency and
// streams the valid elements out one word per valid/ready beat.
module matrix_result_streamer
  import matrix_pkg::*;
#(
  parameter int word_size = 32,
  parameter int Amatrixrownum = 2,
  parameter int Amatrixcolnum = 2,
  parameter int Bmatrixrownum = 2,
  parameter int Bmatrixcolnum = 2,
  parameter int alu_latency = 2,
  localparam int EA = Amatrixrownum * Amatrixcolnum,
  localparam int EB = Bmatrixrownum * Bmatrixcolnum,
  localparam int EN = EA * EB,
  localparam int IW = idx_width(EN),
  localparam int WW = idx_width(alu_latency + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              op,
  input  logic [EN*word_size-1:0] C,
  output logic                    busy,
  output logic [word_size-1:0]    out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_index,
  output logic                    out_last,
  output logic                    done
);

  localparam logic [IW-1:0] LAST_FULL = IW'(EN - 1);
  localparam logic [IW-1:0] LAST_PART = IW'(EA - 1);

  state_t                  state;
  logic [1:0]              op_q;
  logic [WW-1:0]           wait_cnt;
  logic [IW-1:0]           idx;
  logic [EN*word_size-1:0] shadow;

  logic [IW-1:0] last_new;
  logic [IW-1:0] last_cur;
  logic [IW-1:0] idx_next;
  logic          accept;

  // last_new serves the zero-latency path where op is not yet latched
  assign last_new = (op == OP_KRON) ? LAST_FULL : LAST_PART;
  assign last_cur = (op_q == OP_KRON) ? LAST_FULL : LAST_PART;
  assign idx_next = IW'(idx + 1'b1);
  assign accept = out_valid && out_ready;
  assign out_index = idx;

  matrix_result_streamer_mux #(
    .word_size(word_size),
    .depth(EN)
  ) u_mux (
    .data(shadow),
    .sel(idx),
    .elem(out_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q <= '0;
      wait_cnt <= '0;
      idx <= '0;
      shadow <= '0;
      busy <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            wait_cnt <= WW'(alu_latency);
            busy <= 1'b1;
            if (alu_latency == 0) begin
              shadow <= C;
              idx <= '0;
              out_valid <= 1'b1;
              out_last <= (last_new == '0);
              state <= STREAM;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == WW'(1)) begin
            shadow <= C;
            idx <= '0;
            out_valid <= 1'b1;
            out_last <= (last_cur == '0);
            state <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (idx == last_cur) begin
              idx <= '0;
              busy <= 1'b0;
              out_valid <= 1'b0;
              out_last <= 1'b0;
              done <= 1'b1;
              state <= IDLE;
            end else begin
              idx <= idx_next;
              out_last <= (idx_next == last_cur);
            end
          end
        end
        default: begin
          busy <= 1'b0;
          out_valid <= 1'b0;
          out_last <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
